// File: rtl/move_sequencer.sv
// move_sequencer: GoBang placement controller - clears the board, validates and writes a stone, scans for five in a row
// Ports: clock, resetn (synchronous, active-low); put_req, cur_x, cur_y come from the key front-end;
//   mem_addr ({y,x}), mem_we, mem_wdata and mem_rdata (one-cycle read latency) connect to the board RAM;
//   turn, busy, reject, winner_valid and winner are status outputs, all decoded from registers.
module move_sequencer #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3,
  parameter int WIN_LEN = 5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 put_req,
  input  logic [COORD_W-1:0]   cur_x,
  input  logic [COORD_W-1:0]   cur_y,
  output logic [2*COORD_W-1:0] mem_addr,
  output logic                 mem_we,
  output logic [1:0]           mem_wdata,
  input  logic [1:0]           mem_rdata,
  output logic                 turn,
  output logic                 busy,
  output logic                 reject,
  output logic                 winner_valid,
  output logic                 winner
);
  localparam int AW = 2 * COORD_W;
  localparam int SW = COORD_W + 3;
  localparam logic [AW-1:0] LAST  = AW'(BOARD_N * BOARD_N - 1);
  localparam logic [SW-1:0] N_S   = SW'(BOARD_N);
  localparam logic [2:0]    K_MAX = 3'(WIN_LEN - 1);
  localparam logic [3:0]    C_WIN = 4'(WIN_LEN);
  localparam logic [3:0] CLEAR    = 4'd0;
  localparam logic [3:0] IDLE     = 4'd1;
  localparam logic [3:0] RD_CELL  = 4'd2;
  localparam logic [3:0] CHK_CELL = 4'd3;
  localparam logic [3:0] WR       = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_CMP    = 4'd6;
  localparam logic [3:0] EVAL     = 4'd7;
  localparam logic [3:0] OVER     = 4'd8;
  logic [3:0]         state;
  logic [AW-1:0]      clr_addr;
  logic               armed;
  logic               neg;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic [1:0]         dir;
  logic [2:0]         k;
  logic [3:0]         count;
  logic [1:0]         code;
  logic [SW-1:0]      off;
  logic [SW-1:0]      nx;
  logic [SW-1:0]      ny;
  logic               in_b;
  logic               hit;
  logic               more;
  logic               side_end;
  // Neighbour math is done modulo 2^SW: a negative coordinate wraps to a
  // large unsigned value, so a single "< BOARD_N" test covers both edges.
  always_comb begin
    code      = turn ? 2'b10 : 2'b01;
    off       = neg ? -{{COORD_W{1'b0}}, k} : {{COORD_W{1'b0}}, k};
    nx        = {3'b000, px} + (dir == 2'd1 ? '0 : off);
    ny        = {3'b000, py} + (dir == 2'd0 ? '0 : dir == 2'd3 ? -off : off);
    in_b      = nx < N_S && ny < N_S;
    hit       = mem_rdata == code;
    more      = hit && k < K_MAX;
    side_end  = (state == S_ADDR && !in_b) || (state == S_CMP && !more);
    mem_we    = (state == CLEAR && armed) || state == WR;
    mem_wdata = state == WR ? code : 2'b00;
    mem_addr  = state == CLEAR ? clr_addr :
                state == S_ADDR ? {ny[COORD_W-1:0], nx[COORD_W-1:0]} : {py, px};
    busy      = state != IDLE;
  end
  // armed holds off the first clear write until the cycle after reset is released.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      armed        <= 1'b0;
      neg          <= 1'b0;
      px           <= '0;
      py           <= '0;
      dir          <= 2'd0;
      k            <= 3'd1;
      count        <= 4'd1;
      turn         <= 1'b0;
      reject       <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
    end else begin
      reject <= put_req && state != IDLE;
      case (state)
        CLEAR: begin
          armed <= 1'b1;
          if (armed) clr_addr <= clr_addr + AW'(1);
          if (armed && clr_addr == LAST) state <= IDLE;
        end
        IDLE: if (put_req) begin
          px    <= cur_x;
          py    <= cur_y;
          state <= RD_CELL;
        end
        RD_CELL: state <= CHK_CELL;
        CHK_CELL: if (mem_rdata != 2'b00) begin
          reject <= 1'b1;
          state  <= IDLE;
        end else state <= WR;
        WR: begin
          dir   <= 2'd0;
          neg   <= 1'b0;
          k     <= 3'd1;
          count <= 4'd1;
          state <= S_ADDR;
        end
        S_ADDR: if (in_b) state <= S_CMP;
        S_CMP: begin
          count <= count + {3'b000, hit};
          if (more) begin
            k     <= k + 3'd1;
            state <= S_ADDR;
          end
        end
        EVAL: if (count >= C_WIN) begin
          winner       <= turn;
          winner_valid <= 1'b1;
          state        <= OVER;
        end else if (dir != 2'd3) begin
          dir   <= dir + 2'd1;
          neg   <= 1'b0;
          k     <= 3'd1;
          count <= 4'd1;
          state <= S_ADDR;
        end else begin
          turn  <= ~turn;
          state <= IDLE;
        end
        OVER: state <= OVER;
        default: state <= CLEAR;
      endcase
      // End of a side: the + side flips to the - side, the - side finishes the direction.
      if (side_end) begin
        neg   <= 1'b1;
        k     <= 3'd1;
        state <= neg ? EVAL : S_ADDR;
      end
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed self-checking bench for move_sequencer with a board RAM model
module tb_move_sequencer;
  logic       clock;
  logic       resetn;
  logic       put_req;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic       turn;
  logic       busy;
  logic       reject;
  logic       winner_valid;
  logic       winner;
  logic [1:0] mem [64];
  int n_cmp = 0;
  int n_err = 0;

  move_sequencer dut (
    .clock(clock), .resetn(resetn), .put_req(put_req), .cur_x(cur_x), .cur_y(cur_y),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .turn(turn), .busy(busy), .reject(reject), .winner_valid(winner_valid), .winner(winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rst_check(input string t);
    chk({t, "_we"}, 32'(mem_we), 0);
    chk({t, "_addr"}, 32'(mem_addr), 0);
    chk({t, "_wdata"}, 32'(mem_wdata), 0);
    chk({t, "_turn"}, 32'(turn), 0);
    chk({t, "_busy"}, 32'(busy), 1);
    chk({t, "_reject"}, 32'(reject), 0);
    chk({t, "_wv"}, 32'(winner_valid), 0);
    chk({t, "_winner"}, 32'(winner), 0);
  endtask

  task automatic clear_check();
    int nz;
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      chk("clr_write", 32'({busy, mem_we, mem_wdata, mem_addr}), 32'({1'b1, 1'b1, 2'b00, 6'(i)}));
      tick();
    end
    chk("clr_busy65", 32'(busy), 0);
    chk("clr_turn", 32'(turn), 0);
    chk("clr_we_off", 32'(mem_we), 0);
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 2'b00) nz++;
    chk("board_clear", 32'(nz), 0);
  endtask

  task automatic put(input logic [2:0] x, input logic [2:0] y);
    put_req = 1'b1;
    cur_x = x;
    cur_y = y;
    tick();
    put_req = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic play(input logic [2:0] x, input logic [2:0] y);
    put(x, y);
    wait_idle(40);
    chk("play_rej", 32'(reject), 0);
  endtask

  initial begin
    resetn = 1'b0;
    put_req = 1'b0;
    cur_x = 3'd0;
    cur_y = 3'd0;
    ticks(2);
    rst_check("rst");
    clear_check();
    // isolated stone at (3,3), with a stray put during the scan
    put(3'd3, 3'd3);
    chk("rd_busy", 32'(busy), 1);
    ticks(2);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 27);
    chk("wr_data", 32'(mem_wdata), 1);
    chk("wr_rej", 32'(reject), 0);
    ticks(7);
    put(3'd5, 3'd5);
    chk("scan_rej", 32'(reject), 1);
    chk("scan_busy11", 32'(busy), 1);
    ticks(12);
    chk("scan_busy23", 32'(busy), 1);
    tick();
    chk("iso_busy24", 32'(busy), 0);
    chk("iso_turn", 32'(turn), 1);
    chk("iso_rej", 32'(reject), 0);
    chk("iso_cell", 32'(mem[27]), 1);
    chk("stray_cell", 32'(mem[45]), 0);
    // occupied cell
    put(3'd3, 3'd3);
    ticks(2);
    chk("occ_rej", 32'(reject), 1);
    chk("occ_busy", 32'(busy), 0);
    chk("occ_we", 32'(mem_we), 0);
    chk("occ_turn", 32'(turn), 1);
    tick();
    chk("occ_rej_end", 32'(reject), 0);
    chk("occ_cell", 32'(mem[27]), 1);
    // horizontal win for player0 on row 2
    play(3'd7, 3'd7); play(3'd0, 3'd2);
    play(3'd7, 3'd6); play(3'd1, 3'd2);
    play(3'd7, 3'd5); play(3'd3, 3'd2);
    play(3'd7, 3'd4); play(3'd4, 3'd2);
    play(3'd6, 3'd0);
    chk("pre_win_turn", 32'(turn), 0);
    put(3'd2, 3'd2);
    ticks(14);
    chk("hwin_wv15", 32'(winner_valid), 0);
    tick();
    chk("hwin_wv16", 32'(winner_valid), 1);
    chk("hwin_winner", 32'(winner), 0);
    chk("hwin_turn", 32'(turn), 0);
    put(3'd5, 3'd5);
    chk("over_rej", 32'(reject), 1);
    chk("over_busy", 32'(busy), 1);
    chk("over_turn", 32'(turn), 0);
    tick();
    chk("over_rej_end", 32'(reject), 0);
    chk("over_cell", 32'(mem[45]), 0);
    // anti-diagonal win for player1 ending at the edge cell (0,4)
    resetn = 1'b0;
    ticks(2);
    rst_check("rst2");
    clear_check();
    play(3'd7, 3'd7); play(3'd4, 3'd0);
    play(3'd7, 3'd5); play(3'd3, 3'd1);
    play(3'd5, 3'd7); play(3'd2, 3'd2);
    play(3'd7, 3'd3); play(3'd1, 3'd3);
    play(3'd5, 3'd5);
    chk("pre_adiag_turn", 32'(turn), 1);
    put(3'd0, 3'd4);
    ticks(25);
    chk("adiag_wv26", 32'(winner_valid), 0);
    tick();
    chk("adiag_wv27", 32'(winner_valid), 1);
    chk("adiag_winner", 32'(winner), 1);
    chk("adiag_cell", 32'(mem[32]), 2);
    // reset in the middle of a scan
    resetn = 1'b0;
    ticks(2);
    clear_check();
    put(3'd3, 3'd3);
    ticks(11);
    resetn = 1'b0;
    tick();
    rst_check("midrst");
    clear_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
